// File: rtl/core_pipe_exec_mdu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// The op one-hot indices and the FSM state encoding live here.
package core_pipe_exec_mdu_pkg;

  localparam int MDU_OP_MUL    = 0;
  localparam int MDU_OP_MULH   = 1;
  localparam int MDU_OP_MULHSU = 2;
  localparam int MDU_OP_MULHU  = 3;
  localparam int MDU_OP_DIV    = 4;
  localparam int MDU_OP_DIVU   = 5;
  localparam int MDU_OP_REM    = 6;
  localparam int MDU_OP_REMU   = 7;
  localparam int MDU_OPS       = 8;

  // Group masks over the one-hot op vector.
  localparam logic [MDU_OPS-1:0] MDU_OP_D = 8'hF0;
  localparam logic [MDU_OPS-1:0] MDU_OP_R = 8'hC0;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_MUL  = 2'd1,
    MDU_ST_DIV  = 2'd2,
    MDU_ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/core_pipe_exec_mdu_sign.sv
// Operand conditioning: word extension, magnitudes, result sign flags and
// detection of the divide special cases (divide-by-zero, signed overflow).
module core_pipe_exec_mdu_sign
  import core_pipe_exec_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [MDU_OPS-1:0] op,
  input  logic               word,
  input  logic [XLEN-1:0]    rs1,
  input  logic [XLEN-1:0]    rs2,
  output logic [XLEN-1:0]    rs1_ext,
  output logic [XLEN-1:0]    mag1,
  output logic [XLEN-1:0]    mag2,
  output logic               neg_result,
  output logic               neg_rem,
  output logic               div_zero,
  output logic               div_ovf
);

  logic            sgn1, sgn2, is_div, is_rem, n1, n2;
  logic [XLEN-1:0] rs2_ext, min_mag;

  always_comb begin
    sgn1 = op[MDU_OP_MUL] | op[MDU_OP_MULH] | op[MDU_OP_MULHSU] | op[MDU_OP_DIV] | op[MDU_OP_REM];
    sgn2 = op[MDU_OP_MUL] | op[MDU_OP_MULH] | op[MDU_OP_DIV] | op[MDU_OP_REM];
    is_div = |(op & MDU_OP_D);
    is_rem = |(op & MDU_OP_R);

    rs1_ext = rs1;
    rs2_ext = rs2;
    if (word) begin
      rs1_ext = sgn1 ? XLEN'($signed(rs1[31:0])) : XLEN'(rs1[31:0]);
      rs2_ext = sgn2 ? XLEN'($signed(rs2[31:0])) : XLEN'(rs2[31:0]);
    end

    n1   = sgn1 & rs1_ext[XLEN-1];
    n2   = sgn2 & rs2_ext[XLEN-1];
    mag1 = n1 ? -rs1_ext : rs1_ext;
    mag2 = n2 ? -rs2_ext : rs2_ext;

    neg_rem    = n1;
    neg_result = is_rem ? n1 : (n1 ^ n2);

    // Magnitude of the most negative W-bit value is 2^(W-1).
    min_mag = '0;
    if (word) min_mag[31] = 1'b1;
    else      min_mag[XLEN-1] = 1'b1;

    div_zero = is_div && (rs2_ext == '0);
    div_ovf  = is_div && sgn2 && n1 && (mag1 == min_mag) && (rs2_ext == '1);
  end

endmodule

// File: rtl/core_pipe_exec_mdu.sv
// Iterative multiply/divide unit for the execute stage: shift-add multiply
// retiring MUL_UNROLL bits per cycle, restoring divide one bit per cycle.
module core_pipe_exec_mdu
  import core_pipe_exec_mdu_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int MUL_UNROLL   = 1,
  parameter int FAST_SPECIAL = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            valid,
  input  logic            new_instr,
  input  logic            op_mul,
  input  logic            op_mulh,
  input  logic            op_mulhsu,
  input  logic            op_mulhu,
  input  logic            op_div,
  input  logic            op_divu,
  input  logic            op_rem,
  input  logic            op_remu,
  input  logic            op_word,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      fsm_state
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int U  = MUL_UNROLL;
  localparam int AW = XLEN + MUL_UNROLL;

  mdu_state_e state, state_n;
  logic [MDU_OPS-1:0] op, op_r;
  logic word, word_r, neg_res_r, neg_rem_r;
  logic [CW-1:0] cnt, cnt_load;
  // hi/lo hold product halves for multiply, remainder/quotient for divide.
  logic [XLEN-1:0] hi, lo, mcand;

  logic [XLEN-1:0] rs1_ext, mag1, mag2;
  logic neg_result, neg_rem, div_zero, div_ovf, is_div_in, special;

  logic [AW-1:0] add_a, add_b, pp;
  logic          add_sub, div_ok;
  logic [AW:0]   add_sum;
  logic [XLEN-1:0] mul_hi_n, mul_lo_n, div_r_n, div_q_n;
  logic [2*XLEN-1:0] prod_u, prod_s;
  logic [XLEN-1:0] quo, rem, raw, fin, sp_raw, sp;

  assign op = {op_remu, op_rem, op_divu, op_div, op_mulhu, op_mulhsu, op_mulh, op_mul};
  assign word = (XLEN == 64) && op_word;
  assign is_div_in = |(op & MDU_OP_D);
  assign special = (FAST_SPECIAL != 0) && (div_zero || div_ovf);
  assign cnt_load = is_div_in ? CW'(word ? 32 : XLEN) : CW'((word ? 32 : XLEN) / U);
  assign ready = (state == MDU_ST_DONE);
  assign fsm_state = state;

  core_pipe_exec_mdu_sign #(.XLEN(XLEN)) u_sign (
    .op(op), .word(word), .rs1(rs1), .rs2(rs2),
    .rs1_ext(rs1_ext), .mag1(mag1), .mag2(mag2),
    .neg_result(neg_result), .neg_rem(neg_rem),
    .div_zero(div_zero), .div_ovf(div_ovf)
  );

  // Single adder: accumulate partial product in MUL, trial-subtract in DIV.
  always_comb begin
    pp = AW'(mcand) * AW'(lo[U-1:0]);
    if (state == MDU_ST_DIV) begin
      add_a   = AW'({hi, lo[XLEN-1]});
      add_b   = AW'(mcand);
      add_sub = 1'b1;
    end else begin
      add_a   = AW'(hi);
      add_b   = pp;
      add_sub = 1'b0;
    end
  end

  assign add_sum  = {1'b0, add_a} + {1'b0, add_sub ? ~add_b : add_b} + (AW+1)'(add_sub);
  assign mul_hi_n = add_sum[AW-1:U];
  assign mul_lo_n = {add_sum[U-1:0], lo[XLEN-1:U]};
  assign div_ok   = add_sum[AW];
  assign div_r_n  = div_ok ? add_sum[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
  assign div_q_n  = {lo[XLEN-2:0], div_ok};

  // Final result from the values the last iteration is about to write.
  always_comb begin
    prod_u = {mul_hi_n, mul_lo_n};
    prod_s = neg_res_r ? -prod_u : prod_u;
    quo    = neg_res_r ? -div_q_n : div_q_n;
    rem    = neg_rem_r ? -div_r_n : div_r_n;
    raw    = quo;
    if (op_r[MDU_OP_MUL])
      raw = word_r ? XLEN'($signed(prod_s[XLEN-1 -: 32])) : prod_s[XLEN-1:0];
    else if (op_r[MDU_OP_MULH] || op_r[MDU_OP_MULHSU] || op_r[MDU_OP_MULHU])
      raw = prod_s[2*XLEN-1:XLEN];
    else if (|(op_r & MDU_OP_R))
      raw = rem;
    fin = word_r ? XLEN'($signed(raw[31:0])) : raw;

    sp_raw = (|(op & MDU_OP_R)) ? (div_zero ? rs1_ext : '0) : (div_zero ? '1 : rs1_ext);
    sp     = word ? XLEN'($signed(sp_raw[31:0])) : sp_raw;
  end

  always_comb begin
    state_n = state;
    case (state)
      MDU_ST_IDLE: if (valid && !ready)
        state_n = special ? MDU_ST_DONE : (is_div_in ? MDU_ST_DIV : MDU_ST_MUL);
      MDU_ST_MUL, MDU_ST_DIV: begin
        if (!valid) state_n = MDU_ST_IDLE;
        else if (cnt == CW'(1)) state_n = MDU_ST_DONE;
      end
      MDU_ST_DONE: if (new_instr || !valid) state_n = MDU_ST_IDLE;
      default: state_n = MDU_ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) state <= MDU_ST_IDLE;
    else           state <= state_n;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      cnt <= '0; hi <= '0; lo <= '0; mcand <= '0; op_r <= '0;
      word_r <= 1'b0; neg_res_r <= 1'b0; neg_rem_r <= 1'b0; result <= '0;
    end else begin
      case (state)
        MDU_ST_IDLE: if (valid && !ready) begin
          op_r      <= op;
          word_r    <= word;
          // Zero divisor keeps the all-ones quotient unsigned.
          neg_res_r <= neg_result && !div_zero;
          neg_rem_r <= neg_rem;
          hi        <= '0;
          mcand     <= is_div_in ? mag2 : mag1;
          lo        <= is_div_in ? (word ? (mag1 << (XLEN - 32)) : mag1) : mag2;
          cnt       <= cnt_load;
          if (special) result <= sp;
        end
        MDU_ST_MUL: if (valid) begin
          hi  <= mul_hi_n;
          lo  <= mul_lo_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) result <= fin;
        end
        MDU_ST_DIV: if (valid) begin
          hi  <= div_r_n;
          lo  <= div_q_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) result <= fin;
        end
        default: ;
      endcase
    end
  end

  // Exec only accepts an MDU instruction once the result is ready, and holds
  // operands stable from issue until acceptance.
  a_accept_ready: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (valid && new_instr) |-> ready);
  a_stable_ops: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (valid && state != MDU_ST_IDLE) |-> ($stable(rs1) && $stable(rs2) && $stable(op) && $stable(word)));

endmodule

// File: tb/tb_core_pipe_exec_mdu.sv
// Directed bench for core_pipe_exec_mdu: three instances (unroll 1, unroll 4,
// slow special cases) share one stimulus stream; results and latency checked.
module tb_core_pipe_exec_mdu;

  logic        g_clk, g_resetn, valid, new_instr, word;
  logic [7:0]  ops;
  logic [63:0] rs1, rs2;
  logic        rdy [3];
  logic [63:0] res [3];
  logic [1:0]  st  [3];
  logic [63:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    core_pipe_exec_mdu #(
      .XLEN(64), .MUL_UNROLL(k == 1 ? 4 : 1), .FAST_SPECIAL(k == 2 ? 0 : 1)
    ) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .new_instr(new_instr),
      .op_mul(ops[0]), .op_mulh(ops[1]), .op_mulhsu(ops[2]), .op_mulhu(ops[3]),
      .op_div(ops[4]), .op_divu(ops[5]), .op_rem(ops[6]), .op_remu(ops[7]),
      .op_word(word), .rs1(rs1), .rs2(rs2),
      .ready(rdy[k]), .result(res[k]), .fsm_state(st[k])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // valid-rise to ready-rise, counted in clock edges
  function automatic int exp_lat(input int k, input int opi, input bit w, input bit sp);
    int wb, u;
    wb = w ? 32 : 64;
    u  = (k == 1) ? 4 : 1;
    if (opi < 4) return 1 + wb / u;
    if (sp && k != 2) return 1;
    return 1 + wb;
  endfunction

  // driver: issue one op to all instances, wait for ready, consume
  task automatic run_op(input string tag, input int opi, input bit w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input bit sp);
    int lat [3];
    logic [63:0] got [3];
    logic [63:0] e;
    int c;
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0;
      got[k] = '0;
      exp_q.push_back(exp);
    end
    @(negedge g_clk);
    ops = 8'd1 << opi; word = w; rs1 = a; rs2 = b; valid = 1'b1;
    c = 0;
    while (c < 100 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
      @(posedge g_clk); #1;
      c++;
      for (int k = 0; k < 3; k++)
        if (lat[k] == 0 && rdy[k]) begin
          lat[k] = c;
          got[k] = res[k];
        end
    end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      if (lat[k] == 0) check_eq($sformatf("%s/d%0d/ready", tag, k), 64'(rdy[k]), 64'd1);
      else begin
        check_eq($sformatf("%s/d%0d/res", tag, k), got[k], e);
        check_eq($sformatf("%s/d%0d/lat", tag, k), 64'(lat[k]), 64'(exp_lat(k, opi, w, sp)));
      end
    end
    @(negedge g_clk);
    if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) begin
      new_instr = 1'b1;
      @(posedge g_clk); #1;
      check_eq($sformatf("%s/hold", tag), res[0], exp);
      check_eq($sformatf("%s/rdy_drop", tag), 64'(rdy[0]), 64'd0);
      check_eq($sformatf("%s/idle", tag), 64'(st[0]), 64'd0);
      @(negedge g_clk);
    end
    new_instr = 1'b0; valid = 1'b0; ops = '0; word = 1'b0;
  endtask

  initial begin
    g_resetn = 1'b0; valid = 1'b0; new_instr = 1'b0; word = 1'b0;
    ops = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst/d%0d/res", k), res[k], 64'd0);
      check_eq($sformatf("rst/d%0d/rdy", k), 64'(rdy[k]), 64'd0);
      check_eq($sformatf("rst/d%0d/st", k), 64'(st[k]), 64'd0);
    end

    // op indices: 0 mul 1 mulh 2 mulhsu 3 mulhu 4 div 5 divu 6 rem 7 remu
    run_op("mul",     0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op("mulhu",   3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("mulhsu",  2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("mulh",    1, 0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 0);
    run_op("div",     4, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("rem",     6, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("divu",    5, 0, 64'd100, 64'd7, 64'd14, 0);
    run_op("divu0",   5, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu0",   7, 0, 64'd5, 64'd0, 64'd5, 1);
    run_op("div_ovf", 4, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 6, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("divw",    4, 1, 64'h1_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("mulw",    0, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("remw",    6, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("div0",    4, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem0",    6, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1);

    // flush: drop valid after 10 divide iterations
    @(negedge g_clk);
    ops = 8'h10; rs1 = 64'd1000; rs2 = 64'd7; valid = 1'b1;
    repeat (11) @(posedge g_clk);
    @(negedge g_clk);
    valid = 1'b0; ops = '0;
    @(posedge g_clk); #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("flush/d%0d/st", k), 64'(st[k]), 64'd0);
      check_eq($sformatf("flush/d%0d/rdy", k), 64'(rdy[k]), 64'd0);
    end
    repeat (3) @(posedge g_clk);
    #1;
    check_eq("flush/rdy_later", 64'(rdy[0]), 64'd0);

    // reset in the middle of a multiply
    @(negedge g_clk);
    ops = 8'h01; rs1 = 64'd99; rs2 = 64'd3; valid = 1'b1;
    repeat (20) @(posedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b0;
    @(posedge g_clk); #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("midrst/d%0d/rdy", k), 64'(rdy[k]), 64'd0);
      check_eq($sformatf("midrst/d%0d/res", k), res[k], 64'd0);
      check_eq($sformatf("midrst/d%0d/st", k), 64'(st[k]), 64'd0);
    end
    @(negedge g_clk);
    g_resetn = 1'b1; valid = 1'b0; ops = '0;

    run_op("mul_after_rst", 0, 0, 64'd123, 64'd456, 64'h0000_0000_0000_DB18, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
